// File: rtl/core_pkg.sv
// Shared types and constants for the trap/return sequencer: privilege modes,
// FSM states, mstatus bit positions and the fixed interrupt priority list.
package core_pkg;

   typedef enum logic [1:0] {
      PRV_U = 2'b00,
      PRV_S = 2'b01,
      PRV_M = 2'b11
   } prv_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_COMMIT,
      ST_REDIRECT
   } trap_state_t;

   localparam int unsigned MSTATUS_SIE    = 1;
   localparam int unsigned MSTATUS_MIE    = 3;
   localparam int unsigned MSTATUS_SPIE   = 5;
   localparam int unsigned MSTATUS_MPIE   = 7;
   localparam int unsigned MSTATUS_SPP    = 8;
   localparam int unsigned MSTATUS_MPP_LO = 11;
   localparam int unsigned MSTATUS_MPP_HI = 12;
   localparam int unsigned MSTATUS_MPRV   = 17;

   localparam logic [4:0] IRQ_SSI = 5'd1;
   localparam logic [4:0] IRQ_MSI = 5'd3;
   localparam logic [4:0] IRQ_STI = 5'd5;
   localparam logic [4:0] IRQ_MTI = 5'd7;
   localparam logic [4:0] IRQ_SEI = 5'd9;
   localparam logic [4:0] IRQ_MEI = 5'd11;

   // Highest priority first.
   localparam logic [4:0] IRQ_PRIO [6] = '{IRQ_MEI, IRQ_MSI, IRQ_MTI, IRQ_SEI, IRQ_SSI, IRQ_STI};

   // Returns {found, cause} for the highest-priority bit set in the vector.
   function automatic logic [5:0] irq_pick(input logic [31:0] set);
      logic [5:0] r;
      r = '0;
      for (int i = 5; i >= 0; i--) begin
         if (set[IRQ_PRIO[i]]) r = {1'b1, IRQ_PRIO[i]};
      end
      return r;
   endfunction

endpackage

// File: rtl/core_trap_irq_sel.sv
// Interrupt enable, fixed-priority selection and delegation target.
// M-level candidates always beat S-level ones.
module core_trap_irq_sel
   import core_pkg::*;
(
   input  logic [31:0] irq_pending,
   input  logic [31:0] csr_mie,
   input  logic [31:0] csr_mideleg,
   input  logic        mstatus_mie,
   input  logic        mstatus_sie,
   input  prv_mode_t   prv_mode,
   output logic        irq_take,
   output logic [4:0]  irq_cause,
   output prv_mode_t   irq_target
);

   logic [31:0] m_set;
   logic [31:0] s_set;
   logic        m_en;
   logic        s_en;
   logic [5:0]  m_pick;
   logic [5:0]  s_pick;

   always_comb begin
      m_set  = irq_pending & csr_mie & ~csr_mideleg;
      s_set  = irq_pending & csr_mie & csr_mideleg;
      m_en   = (prv_mode != PRV_M) || mstatus_mie;
      s_en   = (prv_mode == PRV_U) || ((prv_mode == PRV_S) && mstatus_sie);
      m_pick = m_en ? irq_pick(m_set) : 6'd0;
      s_pick = s_en ? irq_pick(s_set) : 6'd0;

      irq_take  = m_pick[5] | s_pick[5];
      irq_cause = m_pick[5] ? m_pick[4:0] : s_pick[4:0];

      if ((prv_mode != PRV_M) && csr_mideleg[irq_cause]) irq_target = PRV_S;
      else                                               irq_target = PRV_M;
   end

endmodule

// File: rtl/core_trap_ctrl.sv
// Trap / xRET sequencer: IDLE -> DRAIN -> COMMIT -> REDIRECT -> IDLE.
// Define CORE_TRAP_VECTORED_EN to honour tvec mode 01 for interrupts.
module core_trap_ctrl
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        exc_valid,
   input  logic [4:0]  exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   input  logic        mret_valid,
   input  logic        sret_valid,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic [31:0] irq_pending,
   input  prv_mode_t   prv_mode_ff,
   input  logic [31:0] csr_mstatus_ff,
   input  logic [31:0] csr_medeleg_ff,
   input  logic [31:0] csr_mideleg_ff,
   input  logic [31:0] csr_mie_ff,
   input  logic [31:0] csr_mtvec_ff,
   input  logic [31:0] csr_stvec_ff,
   input  logic [31:0] csr_mepc_ff,
   input  logic [31:0] csr_sepc_ff,
   output logic        busy,
   output logic        flush_req,
   input  logic        flush_ack,
   output logic        redirect_valid,
   input  logic        redirect_ready,
   output logic [31:0] redirect_pc,
   output prv_mode_t   prv_mode_wd,
   output logic        prv_mode_we,
   output logic [31:0] csr_mstatus_wd,
   output logic        csr_mstatus_we,
   output logic [31:0] csr_mepc_wd,
   output logic        csr_mepc_we,
   output logic [31:0] csr_mcause_wd,
   output logic        csr_mcause_we,
   output logic [31:0] csr_mtval_wd,
   output logic        csr_mtval_we,
   output logic [31:0] csr_sepc_wd,
   output logic        csr_sepc_we,
   output logic [31:0] csr_scause_wd,
   output logic        csr_scause_we,
   output logic [31:0] csr_stval_wd,
   output logic        csr_stval_we
);

   // state       | meaning
   // ST_IDLE     | sample events, precompute all writes
   // ST_DRAIN    | flush_req high until flush_ack
   // ST_COMMIT   | single cycle, write ports pulse
   // ST_REDIRECT | redirect_valid high until redirect_ready

   trap_state_t state_q, state_d;
   logic [31:0] mstatus_q, mstatus_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] tval_q, tval_d;
   logic [31:0] redir_q, redir_d;
   prv_mode_t   prv_q, prv_d;
   logic        to_m_q, to_m_d;
   logic        to_s_q, to_s_d;

   logic        irq_take;
   logic [4:0]  irq_cause;
   prv_mode_t   irq_target;

   logic        take_irq;
   logic        intr;
   logic [4:0]  cause;
   prv_mode_t   tgt;
   logic [31:0] ms;
   logic [31:0] tvec;
   logic [31:0] base;
   logic [31:0] vec;
   logic [1:0]  mpp;

   core_trap_irq_sel u_irq_sel (
      .irq_pending (irq_pending),
      .csr_mie     (csr_mie_ff),
      .csr_mideleg (csr_mideleg_ff),
      .mstatus_mie (csr_mstatus_ff[MSTATUS_MIE]),
      .mstatus_sie (csr_mstatus_ff[MSTATUS_SIE]),
      .prv_mode    (prv_mode_ff),
      .irq_take    (irq_take),
      .irq_cause   (irq_cause),
      .irq_target  (irq_target)
   );

   always_comb begin
      take_irq = !exc_valid && commit_valid && irq_take;
      intr     = !exc_valid;
      cause    = exc_valid ? exc_cause : irq_cause;
      if (!exc_valid)                                           tgt = irq_target;
      else if ((prv_mode_ff != PRV_M) && csr_medeleg_ff[cause]) tgt = PRV_S;
      else                                                      tgt = PRV_M;
      tvec = (tgt == PRV_M) ? csr_mtvec_ff : csr_stvec_ff;
      base = tvec & ~32'h3;
`ifdef CORE_TRAP_VECTORED_EN
      vec  = ((tvec[1:0] == 2'b01) && intr) ? base + {25'd0, cause, 2'b00} : base;
`else
      vec  = base;
`endif
      mpp  = csr_mstatus_ff[MSTATUS_MPP_HI:MSTATUS_MPP_LO];

      state_d   = state_q;
      mstatus_d = mstatus_q;
      epc_d     = epc_q;
      cause_d   = cause_q;
      tval_d    = tval_q;
      redir_d   = redir_q;
      prv_d     = prv_q;
      to_m_d    = to_m_q;
      to_s_d    = to_s_q;
      ms        = csr_mstatus_ff;

      case (state_q)
         ST_IDLE: begin
            if (exc_valid || take_irq) begin
               if (tgt == PRV_M) begin
                  ms[MSTATUS_MPIE] = ms[MSTATUS_MIE];
                  ms[MSTATUS_MIE]  = 1'b0;
                  ms[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = prv_mode_ff;
               end else begin
                  ms[MSTATUS_SPIE] = ms[MSTATUS_SIE];
                  ms[MSTATUS_SIE]  = 1'b0;
                  ms[MSTATUS_SPP]  = prv_mode_ff[0];
               end
               mstatus_d = ms;
               epc_d     = (exc_valid ? exc_pc : commit_pc) & ~32'h3;
               cause_d   = {intr, 26'd0, cause};
               tval_d    = exc_valid ? exc_tval : 32'd0;
               redir_d   = vec;
               prv_d     = tgt;
               to_m_d    = (tgt == PRV_M);
               to_s_d    = (tgt == PRV_S);
               state_d   = ST_DRAIN;
            end else if (mret_valid) begin
               ms[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
               ms[MSTATUS_MPIE] = 1'b1;
               ms[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_U;
               if (mpp != PRV_M) ms[MSTATUS_MPRV] = 1'b0;
               mstatus_d = ms;
               redir_d   = csr_mepc_ff;
               prv_d     = prv_mode_t'(mpp);
               to_m_d    = 1'b0;
               to_s_d    = 1'b0;
               state_d   = ST_DRAIN;
            end else if (sret_valid) begin
               ms[MSTATUS_SIE]  = ms[MSTATUS_SPIE];
               ms[MSTATUS_SPIE] = 1'b1;
               ms[MSTATUS_SPP]  = 1'b0;
               ms[MSTATUS_MPRV] = 1'b0;
               mstatus_d = ms;
               redir_d   = csr_sepc_ff;
               prv_d     = prv_mode_t'({1'b0, csr_mstatus_ff[MSTATUS_SPP]});
               to_m_d    = 1'b0;
               to_s_d    = 1'b0;
               state_d   = ST_DRAIN;
            end
         end
         ST_DRAIN:    if (flush_ack) state_d = ST_COMMIT;
         ST_COMMIT:   state_d = ST_REDIRECT;
         ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         mstatus_q <= '0;
         epc_q     <= '0;
         cause_q   <= '0;
         tval_q    <= '0;
         redir_q   <= '0;
         prv_q     <= PRV_U;
         to_m_q    <= 1'b0;
         to_s_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mstatus_q <= mstatus_d;
         epc_q     <= epc_d;
         cause_q   <= cause_d;
         tval_q    <= tval_d;
         redir_q   <= redir_d;
         prv_q     <= prv_d;
         to_m_q    <= to_m_d;
         to_s_q    <= to_s_d;
      end
   end

   logic commit;
   logic wm;
   logic ws;

   always_comb begin
      commit         = (state_q == ST_COMMIT);
      wm             = commit && to_m_q;
      ws             = commit && to_s_q;
      busy           = (state_q != ST_IDLE);
      flush_req      = (state_q == ST_DRAIN);
      redirect_valid = (state_q == ST_REDIRECT);
      redirect_pc    = redirect_valid ? redir_q : 32'd0;
      prv_mode_we    = commit;
      prv_mode_wd    = commit ? prv_q : PRV_U;
      csr_mstatus_we = commit;
      csr_mstatus_wd = commit ? mstatus_q : 32'd0;
      csr_mepc_we    = wm;
      csr_mepc_wd    = wm ? epc_q : 32'd0;
      csr_mcause_we  = wm;
      csr_mcause_wd  = wm ? cause_q : 32'd0;
      csr_mtval_we   = wm;
      csr_mtval_wd   = wm ? tval_q : 32'd0;
      csr_sepc_we    = ws;
      csr_sepc_wd    = ws ? epc_q : 32'd0;
      csr_scause_we  = ws;
      csr_scause_wd  = ws ? cause_q : 32'd0;
      csr_stval_we   = ws;
      csr_stval_wd   = ws ? tval_q : 32'd0;
   end

endmodule

// File: tb/tb_core_trap_ctrl.sv
// Directed bench for core_trap_ctrl; expectations are hand-derived constants.
module tb_core_trap_ctrl;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exc_valid, mret_valid, sret_valid, commit_valid;
   logic [4:0]  exc_cause;
   logic [31:0] exc_pc, exc_tval, commit_pc, irq_pending;
   prv_mode_t   prv_mode_ff;
   logic [31:0] csr_mstatus_ff, csr_medeleg_ff, csr_mideleg_ff, csr_mie_ff;
   logic [31:0] csr_mtvec_ff, csr_stvec_ff, csr_mepc_ff, csr_sepc_ff;
   logic        busy, flush_req, flush_ack, redirect_valid, redirect_ready;
   logic [31:0] redirect_pc;
   prv_mode_t   prv_mode_wd;
   logic        prv_mode_we;
   logic [31:0] csr_mstatus_wd, csr_mepc_wd, csr_mcause_wd, csr_mtval_wd;
   logic [31:0] csr_sepc_wd, csr_scause_wd, csr_stval_wd;
   logic        csr_mstatus_we, csr_mepc_we, csr_mcause_we, csr_mtval_we;
   logic        csr_sepc_we, csr_scause_we, csr_stval_we;

   int checks = 0;
   int failures = 0;

   core_trap_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .mret_valid(mret_valid), .sret_valid(sret_valid),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .irq_pending(irq_pending),
      .prv_mode_ff(prv_mode_ff),
      .csr_mstatus_ff(csr_mstatus_ff), .csr_medeleg_ff(csr_medeleg_ff),
      .csr_mideleg_ff(csr_mideleg_ff), .csr_mie_ff(csr_mie_ff),
      .csr_mtvec_ff(csr_mtvec_ff), .csr_stvec_ff(csr_stvec_ff),
      .csr_mepc_ff(csr_mepc_ff), .csr_sepc_ff(csr_sepc_ff),
      .busy(busy), .flush_req(flush_req), .flush_ack(flush_ack),
      .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
      .prv_mode_wd(prv_mode_wd), .prv_mode_we(prv_mode_we),
      .csr_mstatus_wd(csr_mstatus_wd), .csr_mstatus_we(csr_mstatus_we),
      .csr_mepc_wd(csr_mepc_wd), .csr_mepc_we(csr_mepc_we),
      .csr_mcause_wd(csr_mcause_wd), .csr_mcause_we(csr_mcause_we),
      .csr_mtval_wd(csr_mtval_wd), .csr_mtval_we(csr_mtval_we),
      .csr_sepc_wd(csr_sepc_wd), .csr_sepc_we(csr_sepc_we),
      .csr_scause_wd(csr_scause_wd), .csr_scause_we(csr_scause_we),
      .csr_stval_wd(csr_stval_wd), .csr_stval_we(csr_stval_we)
   );

   always #5 clk = ~clk;

   // Write-port monitor: counts we pulses and snapshots the last commit.
   int          pulses = 0;
   logic [7:0]  cap_mask;
   logic [31:0] cap_ms, cap_epc, cap_cause, cap_tval, cap_prv, cap_redir;
   logic [7:0]  we_vec;
   logic [31:0] wd_or;

   always_comb begin
      we_vec = {prv_mode_we, csr_mstatus_we, csr_mepc_we, csr_mcause_we, csr_mtval_we,
                csr_sepc_we, csr_scause_we, csr_stval_we};
      wd_or  = csr_mstatus_wd | csr_mepc_wd | csr_mcause_wd | csr_mtval_wd |
               csr_sepc_wd | csr_scause_wd | csr_stval_wd | {30'd0, prv_mode_wd};
   end

   always @(negedge clk) begin
      if (we_vec != 8'd0) begin
         pulses    = pulses + 1;
         cap_mask  = we_vec;
         cap_ms    = csr_mstatus_wd;
         cap_epc   = csr_mepc_we   ? csr_mepc_wd   : csr_sepc_wd;
         cap_cause = csr_mcause_we ? csr_mcause_wd : csr_scause_wd;
         cap_tval  = csr_mtval_we  ? csr_mtval_wd  : csr_stval_wd;
         cap_prv   = {30'd0, prv_mode_wd};
      end
      if (redirect_valid) cap_redir = redirect_pc;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      exc_valid = 0; mret_valid = 0; sret_valid = 0; commit_valid = 0;
      exc_cause = 0; exc_pc = 0; exc_tval = 0; commit_pc = 0; irq_pending = 0;
      prv_mode_ff = PRV_M;
      csr_mstatus_ff = 0; csr_medeleg_ff = 0; csr_mideleg_ff = 0; csr_mie_ff = 0;
      csr_mtvec_ff = 0; csr_stvec_ff = 0; csr_mepc_ff = 0; csr_sepc_ff = 0;
      flush_ack = 1; redirect_ready = 1;
   endtask

   // Called at a negedge with the event already driven; returns at a negedge in IDLE.
   task automatic run_event(input string tag);
      int n;
      n = 0;
      @(posedge clk); #1;
      check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
      exc_valid = 0; mret_valid = 0; sret_valid = 0; commit_valid = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         checks++;
         failures++;
         $error("FAIL %s_timeout observed=busy expected=idle", tag);
      end
   endtask

   int p0;
   logic [31:0] exp_redir;

   initial begin
      clear_inputs();
      rst_n = 0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_we", {24'd0, we_vec}, 32'd0);
      rst_n = 1;
      @(negedge clk);
      check("idle_flush", {31'd0, flush_req}, 32'd0);
      check("idle_rv", {31'd0, redirect_valid}, 32'd0);
      check("idle_rpc", redirect_pc, 32'd0);
      check("idle_wd", wd_or, 32'd0);

      // M-mode exception, direct vector
      p0 = pulses;
      prv_mode_ff = PRV_M; csr_mstatus_ff = 32'h0000_0008; csr_mtvec_ff = 32'h8000_0000;
      exc_valid = 1; exc_cause = 5'd2; exc_pc = 32'h8000_0104; exc_tval = 32'h0000_0013;
      run_event("exc_m");
      check("exc_m_pulses", pulses - p0, 32'd1);
      check("exc_m_mask", {24'd0, cap_mask}, 32'h0000_00F8);
      check("exc_m_mepc", cap_epc, 32'h8000_0104);
      check("exc_m_mcause", cap_cause, 32'h0000_0002);
      check("exc_m_mtval", cap_tval, 32'h0000_0013);
      check("exc_m_mstatus", cap_ms, 32'h0000_1880);
      check("exc_m_prv", cap_prv, 32'd3);
      check("exc_m_redir", cap_redir, 32'h8000_0000);

      // U-mode ecall delegated to S
      clear_inputs();
      p0 = pulses;
      prv_mode_ff = PRV_U; csr_medeleg_ff = 32'h0000_0100; csr_mstatus_ff = 32'h0000_0002;
      csr_stvec_ff = 32'hC000_0100; csr_mtvec_ff = 32'h8000_0000;
      exc_valid = 1; exc_cause = 5'd8; exc_pc = 32'h0000_1000; exc_tval = 32'h0;
      run_event("ecall_s");
      check("ecall_s_pulses", pulses - p0, 32'd1);
      check("ecall_s_mask", {24'd0, cap_mask}, 32'h0000_00C7);
      check("ecall_s_sepc", cap_epc, 32'h0000_1000);
      check("ecall_s_scause", cap_cause, 32'h0000_0008);
      check("ecall_s_mstatus", cap_ms, 32'h0000_0020);
      check("ecall_s_prv", cap_prv, 32'd1);
      check("ecall_s_redir", cap_redir, 32'hC000_0100);

      // Interrupt pending but no instruction boundary: ignored
      clear_inputs();
      prv_mode_ff = PRV_S; irq_pending = 32'h0000_0800; csr_mie_ff = 32'h0000_0800;
      repeat (3) @(negedge clk);
      check("irq_nocommit_busy", {31'd0, busy}, 32'd0);

      // S-mode: MEI and STI both pending, MEI wins and goes to M
      clear_inputs();
      p0 = pulses;
      prv_mode_ff = PRV_S; irq_pending = 32'h0000_0820; csr_mie_ff = 32'h0000_0820;
      csr_mideleg_ff = 32'h0000_0020; csr_mstatus_ff = 32'h0000_0002;
      csr_mtvec_ff = 32'h8000_0001; csr_stvec_ff = 32'hC000_0000;
      commit_valid = 1; commit_pc = 32'hC000_2000;
      run_event("mei");
`ifdef CORE_TRAP_VECTORED_EN
      exp_redir = 32'h8000_002C;
`else
      exp_redir = 32'h8000_0000;
`endif
      check("mei_pulses", pulses - p0, 32'd1);
      check("mei_mask", {24'd0, cap_mask}, 32'h0000_00F8);
      check("mei_mcause", cap_cause, 32'h8000_000B);
      check("mei_mepc", cap_epc, 32'hC000_2000);
      check("mei_mtval", cap_tval, 32'h0);
      check("mei_mstatus", cap_ms, 32'h0000_0802);
      check("mei_redir", cap_redir, exp_redir);

      // U-mode delegated STI, misaligned commit_pc gets low bits cleared
      clear_inputs();
      p0 = pulses;
      prv_mode_ff = PRV_U; irq_pending = 32'h0000_0020; csr_mie_ff = 32'h0000_0020;
      csr_mideleg_ff = 32'h0000_0020; csr_stvec_ff = 32'hC000_0001;
      commit_valid = 1; commit_pc = 32'h1234_5676;
      run_event("sti");
`ifdef CORE_TRAP_VECTORED_EN
      exp_redir = 32'hC000_0014;
`else
      exp_redir = 32'hC000_0000;
`endif
      check("sti_mask", {24'd0, cap_mask}, 32'h0000_00C7);
      check("sti_sepc", cap_epc, 32'h1234_5674);
      check("sti_scause", cap_cause, 32'h8000_0005);
      check("sti_prv", cap_prv, 32'd1);
      check("sti_redir", cap_redir, exp_redir);

      // MRET back to S with MPRV cleared
      clear_inputs();
      p0 = pulses;
      prv_mode_ff = PRV_M; csr_mstatus_ff = 32'h0002_0880; csr_mepc_ff = 32'h0000_4000;
      mret_valid = 1;
      run_event("mret");
      check("mret_mask", {24'd0, cap_mask}, 32'h0000_00C0);
      check("mret_mstatus", cap_ms, 32'h0000_0088);
      check("mret_prv", cap_prv, 32'd1);
      check("mret_redir", cap_redir, 32'h0000_4000);

      // SRET with SPP=1, MIE passes through
      clear_inputs();
      p0 = pulses;
      prv_mode_ff = PRV_S; csr_mstatus_ff = 32'h0002_010A; csr_sepc_ff = 32'h0000_5550;
      sret_valid = 1;
      run_event("sret");
      check("sret_mask", {24'd0, cap_mask}, 32'h0000_00C0);
      check("sret_mstatus", cap_ms, 32'h0000_0028);
      check("sret_prv", cap_prv, 32'd1);
      check("sret_redir", cap_redir, 32'h0000_5550);

      // Exception + MRET together, slow flush_ack and redirect_ready
      clear_inputs();
      p0 = pulses;
      prv_mode_ff = PRV_M; csr_mstatus_ff = 32'h0000_0008; csr_mtvec_ff = 32'h8000_0000;
      csr_mepc_ff = 32'h0000_4000;
      exc_valid = 1; exc_cause = 5'd4; exc_pc = 32'h8000_0200; exc_tval = 32'hDEAD_0000;
      mret_valid = 1; flush_ack = 0; redirect_ready = 0;
      @(posedge clk); #1;
      exc_valid = 0; mret_valid = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("slow_flush_req", {31'd0, flush_req}, 32'd1);
         check("slow_drain_busy", {31'd0, busy}, 32'd1);
      end
      flush_ack = 1;
      @(negedge clk);
      check("slow_commit_busy", {31'd0, busy}, 32'd1);
      flush_ack = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("slow_rv", {31'd0, redirect_valid}, 32'd1);
         check("slow_rpc", redirect_pc, 32'h8000_0000);
         check("slow_redir_busy", {31'd0, busy}, 32'd1);
      end
      redirect_ready = 1;
      @(negedge clk);
      check("slow_done_busy", {31'd0, busy}, 32'd0);
      check("slow_pulses", pulses - p0, 32'd1);
      check("slow_mcause", cap_cause, 32'h0000_0004);
      check("slow_mtval", cap_tval, 32'hDEAD_0000);
      check("slow_mstatus", cap_ms, 32'h0000_1880);

      // Reset landing in DRAIN: no writes, outputs cleared immediately
      clear_inputs();
      p0 = pulses;
      prv_mode_ff = PRV_M; csr_mtvec_ff = 32'h8000_0000;
      exc_valid = 1; exc_cause = 5'd5; exc_pc = 32'h8000_0300; flush_ack = 0;
      @(posedge clk); #1;
      exc_valid = 0;
      check("rstd_flush_req", {31'd0, flush_req}, 32'd1);
      @(negedge clk);
      rst_n = 0;
      #1;
      check("rstd_busy", {31'd0, busy}, 32'd0);
      check("rstd_flush", {31'd0, flush_req}, 32'd0);
      @(negedge clk);
      rst_n = 1;
      flush_ack = 1;
      repeat (4) @(negedge clk);
      check("rstd_pulses", pulses - p0, 32'd0);
      check("rstd_idle", {31'd0, busy}, 32'd0);
      check("rstd_rv", {31'd0, redirect_valid}, 32'd0);
      check("rstd_wd", wd_or, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
